// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder: class codes (common with the
// front-end decoder), the padding NOP and the encoder state machine states.
package instr_pkg;

  typedef enum logic [3:0] {
    CLS_MUL    = 4'd0,
    CLS_MULL   = 4'd1,
    CLS_BX     = 4'd2,
    CLS_SWP    = 4'd3,
    CLS_HW_REG = 4'd4,
    CLS_HW_IMM = 4'd5,
    CLS_SIGNED = 4'd6,
    CLS_DP     = 4'd7,
    CLS_LDST   = 4'd8,
    CLS_BLOCK  = 4'd10,
    CLS_BRANCH = 4'd11
  } instr_class_e;

  // MOV r0,r0
  localparam logic [31:0] NOP_WORD = 32'hE1A00000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_PAD,
    ST_DONE
  } enc_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packing of instruction class + fields into a 32-bit ARM word.
// Optional request legality checks are enabled by INSTR_ENCODE_CHECK_EN.
import instr_pkg::*;

module instr_field_pack (
  input  logic [3:0]  i_type,
  input  logic [3:0]  i_cond,
  input  logic [3:0]  i_op,
  input  logic [5:0]  i_flags,
  input  logic [3:0]  i_rn,
  input  logic [3:0]  i_rd,
  input  logic [3:0]  i_rs,
  input  logic [3:0]  i_rm,
  input  logic [23:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_legal
);

  logic       w_imm_form;
  logic [1:0] w_sh;
  logic [3:0] w_lo_nib;
  logic [3:0] w_hi_nib;
  logic [11:0] w_off12;

  always_comb begin
    o_word     = '0;
    o_legal    = 1'b1;
    w_imm_form = 1'b0;
    w_sh       = 2'b01;
    w_lo_nib   = i_rm;
    w_hi_nib   = '0;
    w_off12    = i_imm[11:0];

    unique case (i_type)
      CLS_MUL:
        o_word = {i_cond, 6'b000000, i_flags[1], i_flags[0], i_rd, i_rn, i_rs, 4'b1001, i_rm};
      CLS_MULL:
        o_word = {i_cond, 5'b00001, i_flags[2], i_flags[1], i_flags[0], i_rd, i_rn, i_rs, 4'b1001, i_rm};
      CLS_BX:
        o_word = {i_cond, 24'h12FFF1, i_rm};
      CLS_SWP:
        o_word = {i_cond, 5'b00010, i_flags[2], 2'b00, i_rn, i_rd, 4'b0000, 4'b1001, i_rm};
      // All halfword/signed forms share one layout; SH and the offset source vary.
      CLS_HW_REG, CLS_HW_IMM, CLS_SIGNED: begin
        w_imm_form = (i_type == CLS_HW_IMM) || ((i_type == CLS_SIGNED) && i_flags[5]);
        w_sh       = (i_type == CLS_SIGNED) ? {1'b1, i_op[0]} : 2'b01;
        w_hi_nib   = w_imm_form ? i_imm[7:4] : 4'b0000;
        w_lo_nib   = w_imm_form ? i_imm[3:0] : i_rm;
        o_word = {i_cond, 3'b000, i_flags[4], i_flags[3], w_imm_form, i_flags[1], i_flags[0],
                  i_rn, i_rd, w_hi_nib, 1'b1, w_sh, 1'b1, w_lo_nib};
      end
      CLS_DP:
        o_word = {i_cond, 2'b00, i_flags[5], i_op, i_flags[0], i_rn, i_rd, i_imm[11:0]};
      CLS_LDST: begin
        if (i_flags[5]) w_off12[4] = 1'b0;
        o_word = {i_cond, 2'b01, i_flags, i_rn, i_rd, w_off12};
      end
      CLS_BLOCK:
        o_word = {i_cond, 3'b100, i_flags[4:0], i_rn, i_imm[15:0]};
      CLS_BRANCH:
        o_word = {i_cond, 3'b101, i_flags[0], i_imm};
      default:
        o_legal = 1'b0;
    endcase

`ifdef INSTR_ENCODE_CHECK_EN
    if (((i_type == CLS_MUL) || (i_type == CLS_MULL)) &&
        ((i_rd == i_rm) || (i_rd == 4'hF) || (i_rn == 4'hF) || (i_rs == 4'hF) || (i_rm == 4'hF)))
      o_legal = 1'b0;
    if ((i_type == CLS_SWP) && ((i_rn == 4'hF) || (i_rd == 4'hF) || (i_rm == 4'hF)))
      o_legal = 1'b0;
    if ((i_type == CLS_BLOCK) && (i_imm[15:0] == 16'h0000))
      o_legal = 1'b0;
`endif
  end

endmodule

// File: rtl/instr_encode.sv
// Streaming instruction encoder: FSM, one-word output register and address counter.
// Define INSTR_ENCODE_CHECK_EN to reject malformed mul/swap/block requests.
import instr_pkg::*;

module instr_encode #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned PAD_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_type,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_op,
  input  logic [5:0]        in_flags,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rm,
  input  logic [23:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [15:0]       PAD_N = 16'(PAD_WORDS);

  enc_state_e        r_state, w_state_n;
  logic              r_valid;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_pad_cnt;
  logic              r_err;

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_free, w_handoff, w_accept, w_start_go, w_pad_load, w_pad_end;

  instr_field_pack u_pack (
    .i_type  (in_type),
    .i_cond  (in_cond),
    .i_op    (in_op),
    .i_flags (in_flags),
    .i_rn    (in_rn),
    .i_rd    (in_rd),
    .i_rs    (in_rs),
    .i_rm    (in_rm),
    .i_imm   (in_imm),
    .o_word  (w_word),
    .o_legal (w_legal)
  );

  assign w_free     = !r_valid || out_ready;
  assign w_handoff  = r_valid && out_ready;
  assign in_ready   = (r_state == ST_STREAM) && w_free;
  assign w_accept   = in_valid && in_ready;
  assign w_start_go = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_pad_load = (r_state == ST_PAD) && w_free && (r_pad_cnt != PAD_N);
  // All NOPs loaded and the register drains this cycle: last pad word is handed off.
  assign w_pad_end  = (r_pad_cnt == PAD_N) && w_free;

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_state_n = ST_STREAM;
      ST_STREAM: if (finish) w_state_n = (PAD_WORDS == 0) ? ST_DONE : ST_PAD;
      ST_PAD:    if (w_pad_end) w_state_n = ST_DONE;
      ST_DONE:   w_state_n = start ? ST_STREAM : ST_IDLE;
      default:   w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_word    <= '0;
      r_addr    <= BASE;
      r_pad_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_handoff) r_addr <= r_addr + ADDR_W'(4);
      if (w_start_go) begin
        r_addr    <= BASE;
        r_pad_cnt <= '0;
        r_err     <= 1'b0;
      end

      if (w_accept && w_legal) begin
        r_valid <= 1'b1;
        r_word  <= w_word;
      end else if (w_pad_load) begin
        r_valid   <= 1'b1;
        r_word    <= NOP_WORD;
        r_pad_cnt <= r_pad_cnt + 16'd1;
      end else if (w_handoff) begin
        r_valid <= 1'b0;
      end

      if (w_accept && !w_legal) r_err <= 1'b1;
    end
  end

  assign out_valid = r_valid;
  assign out_word  = r_word;
  assign out_addr  = r_addr;
  assign busy      = (r_state == ST_STREAM) || (r_state == ST_PAD);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encode.sv
// Self-checking bench for instr_encode: arithmetic encoding model + expected-word
// queue checked on every handoff, plus directed literal expectations.
module tb_instr_encode;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned PADN   = 4;

  logic              clk = 1'b0;
  logic              rst, start, finish, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]        in_type, in_cond, in_op, in_rn, in_rd, in_rs, in_rm;
  logic [5:0]        in_flags;
  logic [23:0]       in_imm;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              busy, done, err;

  int n_err = 0;
  int n_checks = 0;
  int n_done = 0;

  logic [31:0] exp_q[$];
  logic [ADDR_W-1:0] m_addr;
  logic        m_err, m_stream, prev_hold;
  logic [31:0] prev_word;
  logic [ADDR_W-1:0] prev_addr;

  instr_encode #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .PAD_WORDS(PADN)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_cond(in_cond),
    .in_op(in_op), .in_flags(in_flags), .in_rn(in_rn), .in_rd(in_rd), .in_rs(in_rs),
    .in_rm(in_rm), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_enc(input logic [3:0] t, input logic [3:0] c,
      input logic [3:0] op, input logic [5:0] f, input logic [3:0] rn, input logic [3:0] rd,
      input logic [3:0] rs, input logic [3:0] rm, input logic [23:0] imm, output bit ok);
    logic [31:0] w;
    logic [11:0] off;
    bit immf;
    logic [1:0] sh;
    w  = {c, 28'h0};
    ok = 1'b1;
    case (t)
      4'd0: w = w | (32'(f[1:0]) << 20) | (32'(rd) << 16) | (32'(rn) << 12) | (32'(rs) << 8) | 32'h90 | 32'(rm);
      4'd1: w = w | 32'h0080_0000 | (32'(f[2:0]) << 20) | (32'(rd) << 16) | (32'(rn) << 12) | (32'(rs) << 8) | 32'h90 | 32'(rm);
      4'd2: w = w | 32'h012F_FF10 | 32'(rm);
      4'd3: w = w | 32'h0100_0000 | (32'(f[2]) << 22) | (32'(rn) << 16) | (32'(rd) << 12) | 32'h90 | 32'(rm);
      4'd4, 4'd5, 4'd6: begin
        immf = (t == 4'd5) || ((t == 4'd6) && f[5]);
        sh   = (t == 4'd6) ? {1'b1, op[0]} : 2'b01;
        w = w | (32'(f[4]) << 24) | (32'(f[3]) << 23) | (32'(f[1]) << 21) | (32'(f[0]) << 20)
              | (32'(rn) << 16) | (32'(rd) << 12) | 32'h90 | (32'(sh) << 5);
        if (immf) w = w | 32'h0040_0000 | (32'(imm[7:4]) << 8) | 32'(imm[3:0]);
        else      w = w | 32'(rm);
      end
      4'd7: w = w | (32'(f[5]) << 25) | (32'(op) << 21) | (32'(f[0]) << 20) | (32'(rn) << 16) | (32'(rd) << 12) | 32'(imm[11:0]);
      4'd8: begin
        off = imm[11:0];
        if (f[5]) off = off & 12'hFEF;
        w = w | 32'h0400_0000 | (32'(f) << 20) | (32'(rn) << 16) | (32'(rd) << 12) | 32'(off);
      end
      4'd10: w = w | 32'h0800_0000 | (32'(f[4:0]) << 20) | (32'(rn) << 16) | 32'(imm[15:0]);
      4'd11: w = w | 32'h0A00_0000 | (32'(f[0]) << 24) | 32'(imm);
      default: ok = 1'b0;
    endcase
`ifdef INSTR_ENCODE_CHECK_EN
    if ((t == 4'd0 || t == 4'd1) && (rd == rm || rd == 15 || rn == 15 || rs == 15 || rm == 15)) ok = 1'b0;
    if (t == 4'd3 && (rn == 15 || rd == 15 || rm == 15)) ok = 1'b0;
    if (t == 4'd10 && imm[15:0] == 16'h0) ok = 1'b0;
`endif
    return w;
  endfunction

  // Compare process: samples 1 ns before each rising edge.
  always @(negedge clk) begin
    logic [31:0] w, e;
    bit ok;
    #4;
    if (rst) begin
      exp_q.delete();
      m_addr = '0; m_err = 1'b0; m_stream = 1'b0; prev_hold = 1'b0;
    end else begin
      chk("err_flag", err, m_err);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", out_word, prev_word);
        chk("hold_addr", out_addr, prev_addr);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", out_word, 32'hxxxx_xxxx);
        else begin
          e = exp_q.pop_front();
          chk("stream_word", out_word, e);
          chk("stream_addr", out_addr, m_addr);
          m_addr = m_addr + 12'd4;
        end
      end
      if (done) n_done++;
      if (start && !m_stream) begin
        m_stream = 1'b1; m_err = 1'b0; m_addr = '0;
      end
      if (in_valid && in_ready) begin
        w = m_enc(in_type, in_cond, in_op, in_flags, in_rn, in_rd, in_rs, in_rm, in_imm, ok);
        if (ok) exp_q.push_back(w);
        else    m_err = 1'b1;
      end
      if (finish && m_stream) begin
        m_stream = 1'b0;
        for (int unsigned k = 0; k < PADN; k++) exp_q.push_back(32'hE1A00000);
      end
      prev_hold = out_valid && !out_ready;
      prev_word = out_word;
      prev_addr = out_addr;
    end
  end

  task automatic send(input logic [3:0] t, input logic [3:0] c, input logic [3:0] op,
      input logic [5:0] f, input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rs,
      input logic [3:0] rm, input logic [23:0] imm, input bit fin);
    bit acc = 1'b0;
    in_valid = 1'b1; in_type = t; in_cond = c; in_op = op; in_flags = f;
    in_rn = rn; in_rd = rd; in_rs = rs; in_rm = rm; in_imm = imm; finish = fin;
    for (int k = 0; k < 50; k++) begin
      #4 acc = in_ready;
      @(negedge clk);
      finish = 1'b0;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1; @(negedge clk); finish = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk("done_seen", seen, 1);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_type = '0; in_cond = '0; in_op = '0; in_flags = '0;
    in_rn = '0; in_rd = '0; in_rs = '0; in_rm = '0; in_imm = '0;

    // Model pins against hand-encoded words.
    chk("pin_dp",     m_enc(4'd7,  4'hE, 4'b0100, 6'b100001, 4'd1, 4'd2, 4'd0, 4'd0, 24'h000005, ok), 32'hE2912005);
    chk("pin_branch", m_enc(4'd11, 4'hE, 4'd0, 6'b000001, 4'd0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, ok), 32'hEBFFFFFE);
    chk("pin_bx",     m_enc(4'd2,  4'hE, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd14, 24'h0, ok), 32'hE12FFF1E);
    chk("pin_ldst",   m_enc(4'd8,  4'hE, 4'd0, 6'b111001, 4'd3, 4'd4, 4'd0, 4'd0, 24'hFFF, ok), 32'hE7934FEF);
    chk("pin_signed", m_enc(4'd6,  4'hE, 4'd1, 6'b110001, 4'd1, 4'd2, 4'd0, 4'd0, 24'h34, ok), 32'hE15123F4);
    chk("pin_hwreg",  m_enc(4'd4,  4'h0, 4'd0, 6'b011001, 4'd6, 4'd7, 4'd0, 4'd8, 24'h0, ok), 32'h019670B8);

    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_word", out_word, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    // Program 1
    pulse_start();
    chk("p1_busy", busy, 1);
    send(4'd12, 4'hE, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0, 1'b0);
    chk("unsup_err", err, 1);
    chk("unsup_no_word", out_valid, 0);
    send(4'd7, 4'hE, 4'b0100, 6'b100001, 4'd1, 4'd2, 4'd0, 4'd0, 24'h000005, 1'b0);
    chk("dp_valid", out_valid, 1);
    chk("dp_word", out_word, 32'hE2912005);
    chk("dp_addr", out_addr, 0);
    out_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_word", out_word, 32'hE2912005);
      chk("stall_addr", out_addr, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(4'd0,  4'hE, 4'd0, 6'b000001, 4'd2, 4'd1, 4'd3, 4'd4,  24'h0,   1'b0);
    send(4'd1,  4'hE, 4'd0, 6'b000100, 4'd4, 4'd5, 4'd3, 4'd2,  24'h0,   1'b0);
    send(4'd3,  4'hE, 4'd0, 6'b000100, 4'd1, 4'd2, 4'd0, 4'd3,  24'h0,   1'b0);
    send(4'd4,  4'h0, 4'd0, 6'b011001, 4'd6, 4'd7, 4'd0, 4'd8,  24'h0,   1'b0);
    send(4'd5,  4'h1, 4'd0, 6'b010000, 4'd2, 4'd3, 4'd0, 4'd0,  24'hAB,  1'b0);
    send(4'd6,  4'hE, 4'd1, 6'b110001, 4'd1, 4'd2, 4'd0, 4'd0,  24'h34,  1'b0);
    send(4'd6,  4'hE, 4'd0, 6'b011001, 4'd1, 4'd2, 4'd0, 4'd9,  24'h0,   1'b0);
    send(4'd8,  4'hE, 4'd0, 6'b111001, 4'd3, 4'd4, 4'd0, 4'd0,  24'hFFF, 1'b0);
    send(4'd8,  4'hE, 4'd0, 6'b011000, 4'd3, 4'd4, 4'd0, 4'd0,  24'h0F0, 1'b0);
    send(4'd10, 4'hE, 4'd0, 6'b001001, 4'd13, 4'd0, 4'd0, 4'd0, 24'h4010, 1'b0);
    n_done = 0;
    send(4'd7,  4'h0, 4'b1101, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    wait_done();
    chk("p1_busy_after", busy, 0);
    repeat (3) @(negedge clk);
    chk("p1_done_once", n_done, 1);
    chk("p1_queue_empty", exp_q.size(), 0);

    // Program 2: branch/BX, then reset during padding
    pulse_start();
    chk("p2_err_cleared", err, 0);
    send(4'd11, 4'hE, 4'd0, 6'b000001, 4'd0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, 1'b0);
    chk("b_word", out_word, 32'hEBFFFFFE);
    chk("b_addr", out_addr, 0);
    send(4'd2, 4'hE, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd14, 24'h0, 1'b0);
    chk("bx_word", out_word, 32'hE12FFF1E);
    chk("bx_addr", out_addr, 4);
    pulse_finish();
    repeat (2) @(negedge clk);
    chk("p2_in_pad", busy, 1);
    rst = 1'b1;
    #1;
    chk("midpad_valid", out_valid, 0);
    chk("midpad_addr", out_addr, 0);
    chk("midpad_busy", busy, 0);
    chk("midpad_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Program 3: optional legality checks
    pulse_start();
    send(4'd0, 4'hE, 4'd0, 6'd0, 4'd1, 4'd3, 4'd2, 4'd3, 24'h0, 1'b0);
`ifdef INSTR_ENCODE_CHECK_EN
    chk("mul_rdrm_err", err, 1);
    chk("mul_rdrm_none", out_valid, 0);
`else
    chk("mul_rdrm_word", out_word, 32'hE0031293);
    chk("mul_rdrm_noerr", err, 0);
`endif
    send(4'd10, 4'hE, 4'd0, 6'd0, 4'd1, 4'd0, 4'd0, 4'd0, 24'h0, 1'b0);
    send(4'd11, 4'h0, 4'd0, 6'd0, 4'd0, 4'd0, 4'd0, 4'd0, 24'h000010, 1'b0);
    chk("p3_branch_word", out_word, 32'h0A000010);
`ifdef INSTR_ENCODE_CHECK_EN
    chk("p3_branch_addr", out_addr, 0);
`else
    chk("p3_branch_addr", out_addr, 8);
`endif
    pulse_finish();
    wait_done();
    repeat (2) @(negedge clk);
    chk("p3_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
